// File: rtl/soc_reset_pkg.sv
// Shared definitions for the reset sequencing blocks: state encoding,
// counter width and elaboration-time sizing helpers.
package soc_reset_pkg;

  localparam int CNT_W   = 8;
  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] PLL_RST   = 3'd0;
  localparam logic [STATE_W-1:0] WAIT_LOCK = 3'd1;
  localparam logic [STATE_W-1:0] STABILIZE = 3'd2;
  localparam logic [STATE_W-1:0] RELEASE   = 3'd3;
  localparam logic [STATE_W-1:0] RUN       = 3'd4;

  typedef logic [CNT_W-1:0] event_cnt_t;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous status bit; output is
// the input delayed through STAGES flops and clears on synchronous reset.
module bit_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_reg[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// Owns the PLL reset request and releases the downstream domain resets one
// by one once lock has been stable; retries the PLL on lock timeout.
module pll_lock_reset_sequencer
  import soc_reset_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int PLL_RST_CYCLES = 16,
  parameter int NUM_DOMAINS    = 3,
  parameter int STAGE_GAP      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_locked,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic [CNT_W-1:0]       lock_loss_cnt,
  output logic [CNT_W-1:0]       retry_cnt
);

  localparam int TIMER_W = clog2(max_int(max_int(LOCK_TIMEOUT, STABLE_CYCLES),
                                         max_int(PLL_RST_CYCLES, STAGE_GAP * NUM_DOMAINS)));
  localparam int IDX_W   = clog2(NUM_DOMAINS + 1);

  localparam logic [TIMER_W-1:0] PULSE_LAST   = TIMER_W'(PLL_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST     = TIMER_W'(STAGE_GAP - 1);
  localparam logic [IDX_W-1:0]   IDX_ALL      = IDX_W'(NUM_DOMAINS);

  logic                   locked_s;
  logic [STATE_W-1:0]     state_reg, state_next;
  logic [TIMER_W-1:0]     timer_reg, timer_next;
  logic [IDX_W-1:0]       rel_idx_reg, rel_idx_next;
  event_cnt_t             lock_loss_reg, lock_loss_next;
  event_cnt_t             retry_reg, retry_next;
  logic                   pll_rst_reg;
  logic                   ready_reg;
  logic [NUM_DOMAINS-1:0] domain_rst_reg, domain_rst_next;
  logic                   released_next;

  bit_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_locked_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in(pll_locked),
    .sync_out(locked_s)
  );

  always_comb begin
    state_next     = state_reg;
    timer_next     = timer_reg;
    rel_idx_next   = rel_idx_reg;
    lock_loss_next = lock_loss_reg;
    retry_next     = retry_reg;

    case (state_reg)
      PLL_RST: begin
        if (timer_reg == PULSE_LAST) begin
          state_next = WAIT_LOCK;
          timer_next = '0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      // A lock seen on the timeout cycle still wins over the retry.
      WAIT_LOCK: begin
        if (locked_s) begin
          state_next = STABILIZE;
          timer_next = '0;
        end else if (timer_reg == TIMEOUT_LAST) begin
          state_next = PLL_RST;
          timer_next = '0;
          retry_next = (retry_reg == {CNT_W{1'b1}}) ? retry_reg : retry_reg + 1'b1;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      STABILIZE: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          timer_next = '0;
        end else if (timer_reg == STABLE_LAST) begin
          state_next   = RELEASE;
          timer_next   = '0;
          rel_idx_next = IDX_W'(1);
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      // rel_idx counts released domains; the timer paces the gap between them.
      RELEASE: begin
        if (!locked_s) begin
          state_next     = WAIT_LOCK;
          timer_next     = '0;
          rel_idx_next   = '0;
          lock_loss_next = (lock_loss_reg == {CNT_W{1'b1}}) ? lock_loss_reg : lock_loss_reg + 1'b1;
        end else if (rel_idx_reg == IDX_ALL) begin
          state_next = RUN;
          timer_next = '0;
        end else if (timer_reg == GAP_LAST) begin
          rel_idx_next = rel_idx_reg + 1'b1;
          timer_next   = '0;
        end else begin
          timer_next = timer_reg + 1'b1;
        end
      end

      RUN: begin
        if (!locked_s) begin
          state_next     = WAIT_LOCK;
          timer_next     = '0;
          rel_idx_next   = '0;
          lock_loss_next = (lock_loss_reg == {CNT_W{1'b1}}) ? lock_loss_reg : lock_loss_reg + 1'b1;
        end
      end

      default: begin
        state_next   = PLL_RST;
        timer_next   = '0;
        rel_idx_next = '0;
      end
    endcase
  end

  assign released_next = (state_next == RELEASE) || (state_next == RUN);

  // Outside RELEASE/RUN the whole vector is asserted, so a partial reset never appears.
  for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_domain
    assign domain_rst_next[gi] = !(released_next && (IDX_W'(gi) < rel_idx_next));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= PLL_RST;
      timer_reg      <= '0;
      rel_idx_reg    <= '0;
      lock_loss_reg  <= '0;
      retry_reg      <= '0;
      pll_rst_reg    <= 1'b1;
      ready_reg      <= 1'b0;
      domain_rst_reg <= '1;
    end else begin
      state_reg      <= state_next;
      timer_reg      <= timer_next;
      rel_idx_reg    <= rel_idx_next;
      lock_loss_reg  <= lock_loss_next;
      retry_reg      <= retry_next;
      pll_rst_reg    <= (state_next == PLL_RST);
      ready_reg      <= (state_next == RUN);
      domain_rst_reg <= domain_rst_next;
    end
  end

  assign pll_rst       = pll_rst_reg;
  assign ready         = ready_reg;
  assign domain_rst    = domain_rst_reg;
  assign lock_loss_cnt = lock_loss_reg;
  assign retry_cnt     = retry_reg;

endmodule
